// File: rtl/sram_like_responder.sv
// SRAM-like slave responder: accepts address handshakes, drives a synchronous RAM,
// and returns in-order data_ok responses LATENCY cycles after acceptance.
module sram_like_responder #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_stall,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CDW = 2;

  function automatic logic [CDW-1:0] sat_dec(input logic [CDW-1:0] v);
    return (v == '0) ? v : v - CDW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CDW-1:0] cd_q [DEPTH];
  logic [CDW-1:0] cd_d [DEPTH];
  logic           dv_q [DEPTH];
  logic           dv_d [DEPTH];
  logic           cap_vld_q, cap_vld_d;
  logic [PW-1:0]  cap_idx_q, cap_idx_d;
  logic           wr_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];

  logic hs;
  logic cap_hit;
  logic head_rdy;
  logic unused_bits;

  // size and the byte offset are not decoded; wstrb and the word address are authoritative
  assign unused_bits = ^{size, addr[1:0]};

  // Request stage: acceptance decided from start-of-cycle occupancy
  assign addr_ok   = ~reset & req & ~addr_stall & (count_q < CW'(DEPTH));
  assign hs        = addr_ok;
  assign ram_en    = hs;
  assign ram_we    = (hs & wr) ? wstrb : 4'b0000;
  assign ram_addr  = {addr[31:2], 2'b00};
  assign ram_wdata = wdata;

  // Response stage: head completes on stored data or on the RAM word arriving this cycle
  assign cap_hit  = cap_vld_q & (cap_idx_q == rptr_q);
  assign head_rdy = (count_q != '0) & (cd_q[rptr_q] == '0) & (dv_q[rptr_q] | cap_hit);
  assign data_ok  = ~reset & head_rdy;

  always_comb begin
    rdata = 32'h0;
    if (data_ok && !wr_q[rptr_q]) begin
      rdata = cap_hit ? ram_rdata : data_q[rptr_q];
    end
  end

  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cd_d      = cd_q;
    dv_d      = dv_q;
    cap_vld_d = hs;
    cap_idx_d = wptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      cd_d[i] = sat_dec(cd_q[i]);
    end
    if (cap_vld_q) begin
      dv_d[cap_idx_q] = 1'b1;
    end
    if (data_ok) begin
      dv_d[rptr_q] = 1'b0;
      rptr_d       = ptr_inc(rptr_q);
    end
    if (hs) begin
      cd_d[wptr_q] = CDW'(LATENCY - 1);
      dv_d[wptr_q] = 1'b0;
      wptr_d       = ptr_inc(wptr_q);
    end
    case ({hs, data_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cd_q[i] <= '0;
        dv_q[i] <= 1'b0;
      end
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      cd_q      <= cd_d;
      dv_q      <= dv_d;
    end
  end

  // Capture stage: payload storage carries no reset, its validity is tracked by dv_q
  always_ff @(posedge clk) begin
    if (hs) begin
      wr_q[wptr_q] <= wr;
    end
    if (cap_vld_q) begin
      data_q[cap_idx_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three instances (LATENCY 1/3/2, DEPTH 2) share one
// directed stimulus stream; a time-based scoreboard predicts every handshake and response.
module tb_sram_like_responder;

  localparam logic [2:0][2:0] LATS = {3'd2, 3'd3, 3'd1};
  localparam int DEP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, wr, addr_stall;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;

  logic [2:0]       addr_ok_w, data_ok_w, ram_en_w;
  logic [2:0][3:0]  ram_we_w;
  logic [2:0][31:0] rdata_w, ram_addr_w, ram_wdata_w;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h0280_0C0C;
    return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] rr;
    always @(posedge clk) rr <= ram_en_w[g] ? ram_val(ram_addr_w[g]) : 32'hDEAD_BEEF;
    sram_like_responder #(.LATENCY(int'(LATS[g])), .DEPTH(DEP)) u_dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok_w[g]), .data_ok(data_ok_w[g]),
      .rdata(rdata_w[g]), .addr_stall(addr_stall), .ram_en(ram_en_w[g]),
      .ram_we(ram_we_w[g]), .ram_addr(ram_addr_w[g]), .ram_wdata(ram_wdata_w[g]),
      .ram_rdata(rr));
  end

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   cnt_m[3];
  int   cyc, n_vec, n_bad;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 3; i++) begin
      logic        eok, edok;
      logic [31:0] erd;
      int          fi;
      exp_t        e;
      fi = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].inst == i) begin
          fi = k;
          break;
        end
      end
      eok  = 1'b0;
      edok = 1'b0;
      if (!reset) begin
        eok  = req && !addr_stall && (cnt_m[i] < DEP);
        edok = (fi >= 0) && (sb[fi].due == cyc);
      end
      erd = edok ? sb[fi].dat : 32'h0;
      chk("addr_ok",   i, 32'(addr_ok_w[i]), 32'(eok));
      chk("ram_en",    i, 32'(ram_en_w[i]),  32'(eok));
      chk("ram_we",    i, 32'(ram_we_w[i]),  (eok && wr) ? 32'(wstrb) : 32'h0);
      chk("ram_addr",  i, ram_addr_w[i],     {addr[31:2], 2'b00});
      chk("ram_wdata", i, ram_wdata_w[i],    wdata);
      chk("data_ok",   i, 32'(data_ok_w[i]), 32'(edok));
      chk("rdata",     i, rdata_w[i],        erd);
      if (edok) begin
        sb.delete(fi);
        cnt_m[i]--;
      end
      if (eok) begin
        e.inst = i;
        e.due  = cyc + int'(LATS[i]);
        e.dat  = wr ? 32'h0 : ram_val({addr[31:2], 2'b00});
        sb.push_back(e);
        cnt_m[i]++;
      end
    end
    if (reset) begin
      sb.delete();
      cnt_m = '{0, 0, 0};
    end
  endtask

  task automatic tick();
    #3;
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input logic r, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d, input logic st);
    req        = r;
    wr         = w;
    wstrb      = s;
    addr       = a;
    wdata      = d;
    addr_stall = st;
    size       = 2'b10;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b1, 4'hF, 32'hFFFF_FFF0, 32'h1234_5678, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_bad = 0;
    cnt_m = '{0, 0, 0};
    reset = 1'b1;
    drv(1'b1, 1'b1, 4'hF, 32'h40, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // first edge after reset: read whose RAM word is 0x02800C0C
    drv(1'b1, 1'b0, 4'h0, 32'h1C00_0003, 32'h0, 1'b0);
    tick();
    idle(4);

    drv(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hAABB_CCDD, 1'b0);
    tick();
    idle(5);

    // request held for four cycles against a DEPTH-2 queue
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 1'b0, 4'h0, 32'h200 + 32'(4 * k), 32'h0, 1'b0);
      tick();
    end
    idle(5);

    repeat (3) begin
      drv(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 1'b1);
      tick();
    end
    drv(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 1'b0);
    tick();
    idle(5);

    // two outstanding reads dropped by a one-cycle reset, then a fresh read
    drv(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0);
    tick();
    drv(1'b1, 1'b0, 4'h0, 32'h404, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    drv(1'b1, 1'b0, 4'h0, 32'h408, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    drv(1'b1, 1'b0, 4'h0, 32'h40C, 32'h0, 1'b0);
    tick();
    idle(5);

    // continuous tagged reads to wrap the pointers several times
    for (int k = 0; k < 12; k++) begin
      drv(1'b1, 1'b0, 4'h0, 32'h3000 + 32'(16 * k), 32'h0, 1'b0);
      tick();
    end
    idle(5);

    for (int k = 0; k < 60; k++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          32'($urandom), 32'($urandom), $urandom_range(0, 4) == 0);
      tick();
    end
    idle(6);

    chk("sb_empty", 0, 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from address handshake to data_ok (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 2, meaning max outstanding accepted requests (legal 1..4).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 SHALL have ports req, wr, size, wstrb, addr and wdata, all inputs, widths 1, 1, 2, 4, 32 and 32, meaning the initiator request fields.
REQ-006 SHALL have port addr_ok, output, 1 bit, meaning request accepted this cycle.
REQ-007 SHALL have ports data_ok and rdata, outputs, widths 1 and 32, meaning response pulse and read data.
REQ-008 SHALL have port addr_stall, input, 1 bit, meaning a bench-driven refusal of acceptance.
REQ-009 SHALL have ports ram_en and ram_we, outputs, widths 1 and 4, meaning RAM enable and byte write enables.
REQ-010 SHALL have ports ram_addr and ram_wdata, outputs, 32 bits each, meaning RAM word address and write data.
REQ-011 SHALL have port ram_rdata, input, 32 bits, meaning synchronous RAM read data, valid one cycle after ram_en.

Function
REQ-012 SHALL assert addr_ok = req & ~addr_stall & (count < DEPTH); a handshake is req & addr_ok in the same cycle.
REQ-013 SHALL compute count from the state at the start of the cycle, so a full queue refuses a request even when it issues data_ok that cycle.
REQ-014 SHALL drive ram_en = handshake, in the handshake cycle itself.
REQ-015 SHALL drive ram_addr = {addr[31:2],2'b00} and ram_wdata = wdata.
REQ-016 SHALL drive ram_we = wstrb when wr=1, and 4'b0 when wr=0; size is not decoded and wstrb is the authority.
REQ-017 SHALL push each accepted request into an in-order circular queue entry holding {wr, countdown = LATENCY-1, data, data_valid}.
REQ-018 SHALL capture ram_rdata into the entry accepted in the previous cycle and set its data_valid.
REQ-019 SHALL decrement every nonzero countdown by 1 per cycle, saturating at 0.
REQ-020 SHALL treat the head entry as ready when countdown == 0 and either data_valid or the capture is occurring this cycle.
REQ-021 SHALL assert data_ok for exactly one cycle when the head is ready, then pop the head; at most one data_ok per cycle, strictly in acceptance order.
REQ-022 SHALL drive rdata from the bypass path (ram_rdata) on a same-cycle capture and from the stored entry otherwise.
REQ-023 SHALL drive rdata = 32'b0 for write responses and whenever data_ok = 0.
REQ-024 SHALL produce data_ok for a lone request exactly LATENCY cycles after its handshake (handshake in cycle N gives data_ok in cycle N+LATENCY).
REQ-025 SHALL give back-to-back handshakes back-to-back data_ok.
REQ-026 SHALL assume the initiator always accepts data_ok (no response backpressure).
REQ-027 SHALL implement read and write pointers of width clog2(DEPTH) (minimum 1) that wrap modulo DEPTH, and a count of width clog2(DEPTH+1).
REQ-028 SHALL let a push and a pop in the same cycle leave count unchanged, with both pointers advancing.
REQ-029 SHALL never accept while count == DEPTH and never pop while count == 0.
REQ-030 SHALL ignore requests with req=0 regardless of the other input values.

Reset
REQ-031 SHALL, on reset asserted at any time, immediately clear count, pointers, all data_valid flags and countdowns.
REQ-032 SHALL hold addr_ok=0, data_ok=0, rdata=0, ram_en=0 and ram_we=0 while reset is high.
REQ-033 SHALL drop all outstanding requests on reset mid-operation, with no data_ok issued for them afterwards.
REQ-034 SHALL permit the first handshake in the first clock edge after reset deasserts.

Verification
REQ-035 SHALL cover: LATENCY=1, read addr=0x1C000003 with ram_rdata=0x02800C0C -> ram_addr=0x1C000000 in handshake cycle N, data_ok=1 and rdata=0x02800C0C in N+1.
REQ-036 SHALL cover: LATENCY=3, DEPTH=2, req held high for 4 cycles -> handshakes in cycles 0 and 1, addr_ok=0 in cycle 2, data_ok in cycles 3 and 4 in order, next handshake in cycle 4 or later.
REQ-037 SHALL cover: write wr=1, wstrb=4'b0011, wdata=0xAABBCCDD -> ram_we=4'b0011 in the handshake cycle, data_ok in N+LATENCY with rdata=0.
REQ-038 SHALL cover: addr_stall=1 for 3 cycles with req=1 -> addr_ok=0 and ram_en=0 throughout, handshake in the first cycle after addr_stall falls.
REQ-039 SHALL cover: LATENCY=2 with 2 requests outstanding, reset pulsed for 1 cycle -> no data_ok for either request, count=0, a fresh request completes normally.
REQ-040 SHALL cover: DEPTH=2 running continuous reads over 8 requests -> pointer wrap without reordering, data_ok sequence matching acceptance order by address tag.
